lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/lap_stopwatch_if.sv | 34 +++
 rtl/lap_stopwatch.sv | 165 ++++++++++++++++
 tb/tb_lap_stopwatch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_stopwatch_if.sv
// Key inputs and display outputs of the lap stopwatch.
// master drives keys/settings; slave is the stopwatch core.
interface lap_stopwatch_if #(
  parameter int TW        = 19,
  parameter int LAP_DEPTH = 4
);
  localparam int LCW = $clog2(LAP_DEPTH + 1);

  logic           key_start_n;
  logic           key_lap_n;
  logic           key_show_n;
  logic           mode_down;
  logic [TW-1:0]  preset;
  logic [TW-1:0]  time_count;
  logic [TW-1:0]  time_display;
  logic [LCW-1:0] lap_count;
  logic           running;
  logic           alarm;
  logic [9:0]     led;

  modport master (
    output key_start_n, key_lap_n, key_show_n,
    output mode_down, preset,
    input  time_count, time_display, lap_count,
    input  running, alarm, led
  );

  modport slave (
    input  key_start_n, key_lap_n, key_show_n,
    input  mode_down, preset,
    output time_count, time_display, lap_count,
    output running, alarm, led
  );
endinterface

// File: rtl/lap_stopwatch.sv
// Centisecond stopwatch: up/countdown, lap history,
// selectable display view and LED position bar.
module lap_stopwatch #(
  parameter int CLK_PER_TICK = 500000,
  parameter int MAX_TIME     = 359999,
  parameter int LAP_DEPTH    = 4,
  parameter int TW           = 19
) (
  input  logic             clk,
  input  logic             rst,
  lap_stopwatch_if.slave   bus
);
  localparam int LCW = $clog2(LAP_DEPTH + 1);
  localparam int PW  =
    (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [TW-1:0]  MAXV  = TW'(MAX_TIME);
  localparam logic [PW-1:0]  PLAST = PW'(CLK_PER_TICK - 1);
  localparam logic [LCW-1:0] LMAX  = LCW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PAUSE, S_DONE
  } state_t;

  state_t         r_state, w_next;
  logic [2:0]     r_k1, r_k2, r_arm;
  logic [2:0]     w_key, w_press;
  logic [PW-1:0]  r_pre;
  logic [TW-1:0]  r_cnt;
  logic           r_dir;
  logic [TW-1:0]  r_lap [LAP_DEPTH];
  logic [LCW-1:0] r_lcnt, r_view;
  logic [TW-1:0]  w_load, w_disp;
  logic [3:0]     w_dig;
  logic [9:0]     w_led;
  logic           w_tick, w_zero, w_clr;
  logic           w_start, w_lap, w_show;
  logic           w_running, w_alarm;

  assign w_key = {bus.key_show_n, bus.key_lap_n,
                  bus.key_start_n};

  // Key sync; a key still held from reset must be
  // released once before it can register a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k1  <= '1;
      r_k2  <= '1;
      r_arm <= '0;
    end else begin
      r_k1  <= w_key;
      r_k2  <= r_k1;
      r_arm <= r_arm | w_key;
    end
  end

  assign w_press = r_k2 & ~r_k1 & r_arm;
  assign w_start = w_press[0];
  assign w_lap   = w_press[1] && (r_state == S_RUN);
  assign w_show  = w_press[2] && (r_state != S_DONE);

  assign w_load = (bus.preset > MAXV) ? MAXV : bus.preset;
  assign w_tick = (r_state == S_RUN) && (r_pre == PLAST);
  assign w_zero = r_dir && w_tick && (r_cnt == TW'(1));
  assign w_clr  = (r_state == S_IDLE) && w_start &&
                  (w_next == S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-decoded status flags.
  always_comb begin
    w_next    = r_state;
    w_running = 1'b0;
    w_alarm   = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_start)
          w_next = (bus.mode_down && w_load == '0)
                   ? S_DONE : S_RUN;
      S_RUN: begin
        w_running = 1'b1;
        if (w_zero)       w_next = S_DONE;
        else if (w_start) w_next = S_PAUSE;
      end
      S_PAUSE:
        if (w_start) w_next = S_RUN;
      S_DONE: begin
        w_alarm = 1'b1;
        if (w_start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Prescaler, live count and direction flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_pre <= '0;
          r_cnt <= bus.mode_down ? w_load : '0;
          r_dir <= bus.mode_down;
        end
        S_RUN: begin
          r_pre <= w_tick ? '0 : r_pre + PW'(1);
          if (w_tick) begin
            if (r_dir)              r_cnt <= r_cnt - TW'(1);
            else if (r_cnt == MAXV) r_cnt <= '0;
            else                    r_cnt <= r_cnt + TW'(1);
          end
        end
        S_PAUSE: ;
        S_DONE: begin
          r_pre <= '0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Lap history and view selection; a lap beats a show.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_lap[i] <= '0;
      r_lcnt <= '0;
      r_view <= '0;
    end else if (w_lap) begin
      for (int i = LAP_DEPTH - 1; i > 0; i--)
        r_lap[i] <= r_lap[i-1];
      r_lap[0] <= r_cnt;
      if (r_lcnt != LMAX) r_lcnt <= r_lcnt + LCW'(1);
      r_view <= '0;
    end else if (w_show) begin
      r_view <= (r_view == r_lcnt) ? '0 : r_view + LCW'(1);
    end
  end

  // Display mux and LED bar.
  always_comb begin
    w_disp = r_cnt;
    for (int i = 0; i < LAP_DEPTH; i++)
      if (r_view == LCW'(i + 1)) w_disp = r_lap[i];
    w_dig = 4'((r_cnt / TW'(100)) % TW'(10));
    w_led = 10'h000;
    if (r_state == S_RUN || r_state == S_PAUSE)
      w_led = 10'h200 >> w_dig;
    else if (r_state == S_DONE)
      w_led = 10'h3FF;
  end

  assign bus.time_count   = r_cnt;
  assign bus.time_display = w_disp;
  assign bus.lap_count    = r_lcnt;
  assign bus.running      = w_running;
  assign bus.alarm        = w_alarm;
  assign bus.led          = w_led;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with a queued
// scoreboard checked on the falling clock edge.
module tb_lap_stopwatch;
  localparam int TW = 19;
  localparam int LD = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lap_stopwatch_if #(.TW(TW), .LAP_DEPTH(LD)) bus ();

  lap_stopwatch #(
    .CLK_PER_TICK(2),
    .MAX_TIME(249),
    .LAP_DEPTH(LD),
    .TW(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  localparam int CNT = 0, DSP = 1, LCN = 2;
  localparam int RUN = 3, ALM = 4, LED = 5;

  function automatic logic [31:0] get(int s);
    case (s)
      CNT:     return 32'(bus.time_count);
      DSP:     return 32'(bus.time_display);
      LCN:     return 32'(bus.lap_count);
      RUN:     return 32'(bus.running);
      ALM:     return 32'(bus.alarm);
      default: return 32'(bus.led);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = get(e.sel);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %0h want %0h",
                 e.name, act, e.val);
      end
    end
  end

  task automatic ex(string n, int s, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(logic [2:0] k);
    bus.key_start_n = ~k[0];
    bus.key_lap_n   = ~k[1];
    bus.key_show_n  = ~k[2];
    step(1);
    bus.key_start_n = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.key_show_n  = 1'b1;
    step(1);
  endtask

  task automatic all_zero(string n);
    ex({n, ".cnt"}, CNT, 0);
    ex({n, ".dsp"}, DSP, 0);
    ex({n, ".lcnt"}, LCN, 0);
    ex({n, ".run"}, RUN, 0);
    ex({n, ".alm"}, ALM, 0);
    ex({n, ".led"}, LED, 0);
  endtask

  initial begin
    bus.key_start_n = 1'b1;
    bus.key_lap_n   = 1'b1;
    bus.key_show_n  = 1'b1;
    bus.mode_down   = 1'b0;
    bus.preset      = '0;
    rst = 1'b1;
    step(3);
    all_zero("reset");
    rst = 1'b0;
    step(1);

    // up count, pause, resume
    press(3'b001);
    ex("up.run", RUN, 1); ex("up.cnt0", CNT, 0);
    ex("up.led", LED, 10'h200);
    step(19);
    ex("up.cnt9", CNT, 9);
    press(3'b001);
    ex("pause.cnt", CNT, 10); ex("pause.run", RUN, 0);
    step(50);
    ex("hold.cnt", CNT, 10);
    ex("hold.led", LED, 10'h200);
    press(3'b001);
    ex("resume.cnt", CNT, 10); ex("resume.run", RUN, 1);
    step(1);
    ex("resume.cnt11", CNT, 11);

    // laps; each lap lands on a tick edge
    press(3'b010);
    ex("lap1.lcnt", LCN, 1); ex("lap1.cnt", CNT, 12);
    ex("lap1.dsp", DSP, 12);
    press(3'b010);
    ex("lap2.lcnt", LCN, 2); ex("lap2.cnt", CNT, 13);
    press(3'b010);
    ex("lap3.lcnt", LCN, 2); ex("lap3.cnt", CNT, 14);
    press(3'b100);
    ex("show1.dsp", DSP, 13);
    press(3'b100);
    ex("show2.dsp", DSP, 12);
    press(3'b100);
    ex("show0.dsp", DSP, 17);
    press(3'b100);
    ex("show1b.dsp", DSP, 13);
    press(3'b110);
    ex("lapwin.dsp", DSP, 19);
    ex("lapwin.lcnt", LCN, 2);
    press(3'b100);
    ex("lapwin.lap0", DSP, 18);

    // keys in pause
    press(3'b001);
    ex("p2.cnt", CNT, 21); ex("p2.run", RUN, 0);
    press(3'b010);
    ex("plap.lcnt", LCN, 2); ex("plap.dsp", DSP, 18);
    press(3'b100);
    ex("pshow.dsp", DSP, 13);
    press(3'b001);
    ex("r2.run", RUN, 1); ex("r2.cnt", CNT, 21);

    // reset mid-run with start held low
    bus.key_start_n = 1'b0;
    rst = 1'b1;
    step(2);
    all_zero("midrst");
    rst = 1'b0;
    step(4);
    ex("held.run", RUN, 0); ex("held.cnt", CNT, 0);
    bus.key_start_n = 1'b1;
    step(2);
    press(3'b001);
    ex("repress.run", RUN, 1);

    // countdown
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.mode_down = 1'b1;
    bus.preset    = 19'd3;
    step(1);
    ex("dn.load", CNT, 3);
    press(3'b001);
    ex("dn.run", RUN, 1); ex("dn.cnt3", CNT, 3);
    step(5);
    ex("dn.cnt1", CNT, 1); ex("dn.run1", RUN, 1);
    step(1);
    ex("done.cnt", CNT, 0); ex("done.alm", ALM, 1);
    ex("done.led", LED, 10'h3FF); ex("done.run", RUN, 0);
    press(3'b110);
    ex("done.ign.alm", ALM, 1);
    ex("done.ign.lcnt", LCN, 0);
    ex("done.ign.dsp", DSP, 0);
    press(3'b001);
    ex("ack.alm", ALM, 0); ex("ack.led", LED, 0);
    ex("ack.run", RUN, 0);
    step(1);
    ex("ack.cnt", CNT, 3);

    // zero preset goes straight to done
    bus.preset = '0;
    step(1);
    press(3'b001);
    ex("z.alm", ALM, 1); ex("z.run", RUN, 0);
    press(3'b001);
    ex("z.ack", ALM, 0);

    // preset clamp and LED digit
    bus.preset = 19'd300;
    step(1);
    ex("clamp.cnt", CNT, 249); ex("clamp.led", LED, 0);
    press(3'b001);
    ex("clamp.run", RUN, 1);
    ex("clamp.led2", LED, 10'h080);
    step(2);
    ex("clamp.dec", CNT, 248);

    // up-count wrap at MAX_TIME
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.mode_down = 1'b0;
    step(1);
    ex("w.idle", CNT, 0);
    press(3'b001);
    step(300);
    ex("w.cnt150", CNT, 150); ex("w.led1", LED, 10'h100);
    step(198);
    ex("w.max", CNT, 249); ex("w.led2", LED, 10'h080);
    step(2);
    ex("w.wrap", CNT, 0); ex("w.run", RUN, 1);
    ex("w.led0", LED, 10'h200);
    step(2);
    ex("w.cont", CNT, 1);

    step(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
